// File: rtl/atoi_ctl.sv
// Token-to-integer sequencer: strips one optional base prefix from a counted
// token, drives the atoi engine over the remaining bytes and judges the result.
module atoi_ctl #(
  parameter int ASZ = 17,
  parameter int DSZ = 32
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           req,
  input  logic           base_hex,
  input  logic [ASZ-1:0] tib,
  input  logic [7:0]     len,
  output logic [ASZ-1:0] ai,
  input  logic [7:0]     ch,
  output logic           a2i_en,
  output logic           a2i_hex,
  input  logic           a2i_bsy,
  input  logic           a2i_af,
  input  logic [DSZ-1:0] a2i_vo,
  output logic           busy,
  output logic           ack,
  output logic           ok,
  output logic [DSZ-1:0] vo,
  output logic [7:0]     nc
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    CHK   = 3'd2,
    RUN   = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam logic [7:0] CH_DOLLAR = 8'h24;
  localparam logic [7:0] CH_HASH   = 8'h23;

  state_t         state_reg, state_next;
  logic [ASZ-1:0] ai_reg;
  logic [7:0]     rem_reg;
  logic           hex_reg;
  logic           pfx_reg;
  logic [7:0]     cnt_reg, cnt_next;
  logic           sgn_reg;
  logic [9:0]     wd_reg;
  logic           armed_reg;
  logic           ok_reg;
  logic [DSZ-1:0] vo_reg;
  logic [7:0]     nc_reg;

  logic           is_pfx;
  logic [9:0]     wd_lim;
  logic           run_fin, run_ovr, run_wdg, run_exit, run_ok;

  // Only the first prefix byte is special; a second one goes to the engine.
  assign is_pfx   = !pfx_reg && ((ch == CH_DOLLAR) || (ch == CH_HASH));
  assign wd_lim   = {1'b0, rem_reg, 1'b0} + 10'd8;
  assign cnt_next = cnt_reg + {7'd0, a2i_af};

  // The engine's busy flag is not yet meaningful in its first enabled cycle.
  assign run_fin  = armed_reg && !a2i_bsy;
  assign run_ovr  = cnt_reg > rem_reg;
  assign run_wdg  = wd_reg == wd_lim;
  assign run_exit = run_fin || run_ovr || run_wdg;
  assign run_ok   = run_fin && (cnt_reg == rem_reg) && (cnt_reg > {7'd0, sgn_reg});

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:  if (req) state_next = FETCH;
      FETCH: state_next = CHK;
      CHK: begin
        if (rem_reg == 8'd0) begin
          state_next = DONE;
        end else if (is_pfx) begin
          state_next = FETCH;
        end else begin
          state_next = RUN;
        end
      end
      RUN:   if (run_exit) state_next = DONE;
      DONE:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy    = state_reg != IDLE;
    ack     = state_reg == DONE;
    a2i_en  = state_reg == RUN;
    a2i_hex = (state_reg == RUN) && hex_reg;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ai_reg    <= '0;
      rem_reg   <= '0;
      hex_reg   <= 1'b0;
      pfx_reg   <= 1'b0;
      cnt_reg   <= '0;
      sgn_reg   <= 1'b0;
      wd_reg    <= '0;
      armed_reg <= 1'b0;
      ok_reg    <= 1'b0;
      vo_reg    <= '0;
      nc_reg    <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (req) begin
            ai_reg    <= tib;
            rem_reg   <= len;
            hex_reg   <= base_hex;
            pfx_reg   <= 1'b0;
            cnt_reg   <= '0;
            sgn_reg   <= 1'b0;
            wd_reg    <= '0;
            armed_reg <= 1'b0;
          end
        end
        CHK: begin
          if (rem_reg == 8'd0) begin
            ok_reg <= 1'b0;
            nc_reg <= cnt_reg;
          end else if (is_pfx) begin
            hex_reg <= (ch == CH_DOLLAR);
            pfx_reg <= 1'b1;
            ai_reg  <= ai_reg + {{(ASZ-1){1'b0}}, 1'b1};
            rem_reg <= rem_reg - 8'd1;
          end else begin
            // wd counts RUN cycles including the current one.
            wd_reg    <= 10'd1;
            armed_reg <= 1'b0;
          end
        end
        RUN: begin
          ai_reg    <= ai_reg + {{(ASZ-1){1'b0}}, a2i_af};
          cnt_reg   <= cnt_next;
          wd_reg    <= wd_reg + 10'd1;
          armed_reg <= 1'b1;
          if (!armed_reg) begin
            sgn_reg <= a2i_af;
          end
          if (run_exit) begin
            ok_reg <= run_ok;
            vo_reg <= a2i_vo;
            nc_reg <= cnt_next;
          end
        end
        default: ;
      endcase
    end
  end

  assign ai = ai_reg;
  assign ok = ok_reg;
  assign vo = vo_reg;
  assign nc = nc_reg;

endmodule

// File: tb/tb_atoi_ctl.sv
// Directed bench for atoi_ctl with a small behavioural atoi engine and a
// registered byte memory behind ai/ch.
module tb_atoi_ctl;

  localparam int ASZ = 17;
  localparam int DSZ = 32;

  logic           clk = 1'b0;
  logic           rst;
  logic           req;
  logic           base_hex;
  logic [ASZ-1:0] tib;
  logic [7:0]     len;
  logic [ASZ-1:0] ai;
  logic [7:0]     ch;
  logic           a2i_en;
  logic           a2i_hex;
  logic           a2i_bsy;
  logic           a2i_af;
  logic [DSZ-1:0] a2i_vo;
  logic           busy;
  logic           ack;
  logic           ok;
  logic [DSZ-1:0] vo;
  logic [7:0]     nc;

  int n_checks = 0;
  int n_errors = 0;

  atoi_ctl #(.ASZ(ASZ), .DSZ(DSZ)) dut (
    .clk(clk), .rst(rst), .req(req), .base_hex(base_hex), .tib(tib), .len(len),
    .ai(ai), .ch(ch), .a2i_en(a2i_en), .a2i_hex(a2i_hex), .a2i_bsy(a2i_bsy),
    .a2i_af(a2i_af), .a2i_vo(a2i_vo), .busy(busy), .ack(ack), .ok(ok),
    .vo(vo), .nc(nc)
  );

  always #5 clk = ~clk;

  // Byte memory: data for ai appears one cycle later.
  logic [7:0] mem [0:(1<<ASZ)-1];
  always @(posedge clk) ch <= mem[ai];

  // Engine model: start cycle (consumes '-'), then 2 cycles per digit.
  localparam logic [1:0] E_START = 2'd0, E_DIG = 2'd1, E_WAIT = 2'd2, E_END = 2'd3;
  logic [1:0]  e_st;
  logic [31:0] acc;
  logic        neg;
  bit          stuck = 1'b0;
  logic [4:0]  dv;

  function automatic logic [4:0] dig(input logic [7:0] c, input logic hx);
    logic [7:0] t;
    t = 8'd0;
    if (c >= 8'h30 && c <= 8'h39) begin
      t = c - 8'h30;
      return {1'b1, t[3:0]};
    end
    if (hx && c >= 8'h41 && c <= 8'h46) begin
      t = c - 8'h37;
      return {1'b1, t[3:0]};
    end
    if (hx && c >= 8'h61 && c <= 8'h66) begin
      t = c - 8'h57;
      return {1'b1, t[3:0]};
    end
    return 5'd0;
  endfunction

  assign dv      = dig(ch, a2i_hex);
  assign a2i_bsy = a2i_en && (stuck || e_st != E_END);
  assign a2i_af  = a2i_en && !stuck &&
                   ((e_st == E_START && ch == 8'h2D) || (e_st == E_DIG && dv[4]));
  assign a2i_vo  = neg ? -acc : acc;

  always_ff @(posedge clk) begin
    if (!a2i_en) begin
      e_st <= E_START;
      acc  <= 32'd0;
      neg  <= 1'b0;
    end else if (!stuck) begin
      case (e_st)
        E_START: begin
          if (ch == 8'h2D) begin
            neg  <= 1'b1;
            e_st <= E_WAIT;
          end else begin
            e_st <= E_DIG;
          end
        end
        E_DIG: begin
          if (dv[4]) begin
            acc  <= acc * (a2i_hex ? 32'd16 : 32'd10) + {28'd0, dv[3:0]};
            e_st <= E_WAIT;
          end else begin
            e_st <= E_END;
          end
        end
        E_WAIT: e_st <= E_DIG;
        default: ;
      endcase
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic load(input logic [ASZ-1:0] addr, input string s);
    for (int i = 0; i < s.len(); i++) mem[addr + ASZ'(i)] = s[i];
  endtask

  // Issue one req and wait for ack; lat counts cycles from the accepting edge.
  task automatic run_tok(input logic [ASZ-1:0] addr, input logic [7:0] l, input logic bh,
                         output int lat, output bit en_seen, output logic [31:0] vo_mid);
    @(negedge clk);
    tib = addr; len = l; base_hex = bh; req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    lat = 1;
    en_seen = a2i_en;
    vo_mid = vo;
    while (!ack && lat < 600) begin
      @(negedge clk);
      lat++;
      en_seen |= a2i_en;
      if (lat == 2) vo_mid = vo;
    end
    check("ack_seen", {31'd0, ack}, 32'd1);
  endtask

  int          lat;
  bit          en_seen;
  logic [31:0] vo_mid;
  int          acks;

  initial begin
    for (int i = 0; i < (1 << ASZ); i++) mem[i] = 8'h20;
    load(17'h100, "123");
    load(17'h110, "$1F");
    load(17'h120, "#10");
    load(17'h130, "-45");
    load(17'h140, "-");
    load(17'h150, "12x");
    load(17'h170, "77");

    rst = 1'b1; req = 1'b0; base_hex = 1'b0; tib = '0; len = '0;
    repeat (3) @(negedge clk);
    check("rst_ack", {31'd0, ack}, 0);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_en", {31'd0, a2i_en}, 0);
    check("rst_hex", {31'd0, a2i_hex}, 0);
    check("rst_ok", {31'd0, ok}, 0);
    check("rst_vo", vo, 0);
    check("rst_nc", {24'd0, nc}, 0);
    check("rst_ai", {15'd0, ai}, 0);
    rst = 1'b0;

    run_tok(17'h100, 8'd3, 1'b0, lat, en_seen, vo_mid);
    check("dec_ok", {31'd0, ok}, 1);
    check("dec_vo", vo, 123);
    check("dec_nc", {24'd0, nc}, 3);
    check("dec_ai", {15'd0, ai}, 32'h103);
    check("dec_lat_le_13", {31'd0, lat <= 13}, 1);
    @(negedge clk);
    check("ack_1cyc", {31'd0, ack}, 0);
    check("busy_after", {31'd0, busy}, 0);

    run_tok(17'h110, 8'd3, 1'b0, lat, en_seen, vo_mid);
    check("hexpfx_hold_vo", vo_mid, 123);
    check("hexpfx_ok", {31'd0, ok}, 1);
    check("hexpfx_vo", vo, 32'h1F);
    check("hexpfx_nc", {24'd0, nc}, 2);
    check("hexpfx_ai", {15'd0, ai}, 32'h113);

    run_tok(17'h120, 8'd3, 1'b1, lat, en_seen, vo_mid);
    check("decpfx_ok", {31'd0, ok}, 1);
    check("decpfx_vo", vo, 10);
    check("decpfx_nc", {24'd0, nc}, 2);

    run_tok(17'h130, 8'd3, 1'b0, lat, en_seen, vo_mid);
    check("neg_ok", {31'd0, ok}, 1);
    check("neg_vo", vo, 32'hFFFF_FFD3);
    check("neg_nc", {24'd0, nc}, 3);

    run_tok(17'h140, 8'd1, 1'b0, lat, en_seen, vo_mid);
    check("sign_only_ok", {31'd0, ok}, 0);
    check("sign_only_nc", {24'd0, nc}, 1);

    run_tok(17'h150, 8'd3, 1'b0, lat, en_seen, vo_mid);
    check("trail_ok", {31'd0, ok}, 0);
    check("trail_vo", vo, 12);
    check("trail_nc", {24'd0, nc}, 2);

    run_tok(17'h160, 8'd0, 1'b0, lat, en_seen, vo_mid);
    check("len0_lat", lat, 3);
    check("len0_ok", {31'd0, ok}, 0);
    check("len0_en", {31'd0, en_seen}, 0);

    run_tok(17'h100, 8'd2, 1'b0, lat, en_seen, vo_mid);
    check("overrun_ok", {31'd0, ok}, 0);
    check("overrun_vo", vo, 123);
    check("overrun_nc", {24'd0, nc}, 3);

    stuck = 1'b1;
    run_tok(17'h170, 8'd2, 1'b0, lat, en_seen, vo_mid);
    check("wdog_lat", lat, 15);
    check("wdog_ok", {31'd0, ok}, 0);
    check("wdog_nc", {24'd0, nc}, 0);
    stuck = 1'b0;

    // Second req while busy must be ignored.
    @(negedge clk);
    tib = 17'h100; len = 8'd3; base_hex = 1'b0; req = 1'b1;
    @(negedge clk);
    acks = 0;
    for (int i = 0; i < 40; i++) begin
      req = (i == 4);
      @(negedge clk);
      if (ack) acks++;
    end
    req = 1'b0;
    check("req_busy_acks", acks, 1);
    check("req_busy_vo", vo, 123);

    // Reset in the middle of RUN.
    @(negedge clk);
    tib = 17'h100; len = 8'd3; base_hex = 1'b0; req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    repeat (4) @(negedge clk);
    check("mid_en_before", {31'd0, a2i_en}, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_busy", {31'd0, busy}, 0);
    check("mid_rst_en", {31'd0, a2i_en}, 0);
    check("mid_rst_vo", vo, 0);
    check("mid_rst_nc", {24'd0, nc}, 0);
    acks = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (ack) acks++;
    end
    check("mid_rst_no_ack", acks, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
